cmd_queue_fifo: RTL and testbench
=================================

// Module: cmd_queue_fifo
// PURPOSE
//  Parametrised show-ahead command FIFO between the host-side command source and the issuer.
//  Replaces the behavioural command array used in simulation with synthesizable storage.
//  Exposes the issuer-facing cmd/empty/rd handshake, plus fill-level and error status.
//  Supports flush and an optional empty-bypass path.
// PARAMETERS
//  CMD_W        64  width of one command word (matches packed cmd_t)
//  DEPTH        16  entries; power of two, >= 2
//  AFULL_THRESH 12  o_almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
// PORTS
//  i_clk          in   1                clock, rising edge
//  i_rstn         in   1                async active-low reset
//  i_flush        in   1                sync flush: drop all entries, clear error flags
//  i_push         in   1                enqueue i_push_cmd this cycle
//  i_push_cmd     in   CMD_W            command to enqueue
//  o_full         out  1                no free entry
//  o_almost_full  out  1                count >= AFULL_THRESH
//  o_cmd          out  CMD_W            head command; valid while !o_empty
//  o_empty        out  1                no command available
//  i_rd           in   1                issuer pops head (issuer_rd_queue)
//  o_count        out  $clog2(DEPTH)+1  entries stored
//  o_overflow     out  1                sticky: push while full
//  o_underflow    out  1                sticky: rd while empty
// BEHAVIOUR
//  - Reset (async, i_rstn=0): rd/wr pointers=0, o_count=0, o_empty=1, o_full=0,
//    o_almost_full=0, o_overflow=0, o_underflow=0, o_cmd=0. Takes effect mid-operation at once.
//  - Storage: DEPTH x CMD_W regs; pointers $clog2(DEPTH)+1 bits, MSB = wrap bit;
//    full = addr equal & wrap differ; empty = pointers equal. Pointers wrap modulo 2*DEPTH.
//  - Push accepted iff i_push && !o_full (o_full from current registered state; a same-cycle
//    rd does NOT free a slot). Push while full: dropped, o_overflow<=1.
//  - Pop accepted iff i_rd && !o_empty; head advances next edge. Rd while empty: ignored,
//    o_underflow<=1.
//  - Show-ahead: o_cmd = mem[rd_ptr] combinationally; push->visible latency 1 cycle.
//  - Push+pop same cycle (not full, not empty): count unchanged, both pointers advance.
//  - o_count/o_full/o_almost_full/o_empty derived from registered pointers, update next edge.
//  - i_flush: priority over push/pop same cycle; next edge pointers=0, count=0, flags=0;
//    storage contents not cleared.
//  - o_cmd when o_empty: 0 (masked), never stale data.
//  - Sticky flags clear only on reset or flush.
// CONFIGURATION
//  CMDQ_BYPASS_EN defined: when FIFO empty and i_push, o_cmd=i_push_cmd and o_empty=0
//    combinationally same cycle; if i_rd also high, command consumed without being stored
//    (count stays 0, no underflow). Not asserted during i_flush.
//  CMDQ_BYPASS_EN undefined: no bypass; min push->pop latency 1 cycle; rd in push cycle on
//    empty FIFO sets o_underflow.
// TESTING
//  1 reset: hold i_rstn=0 mid-stream with 5 entries -> all outputs at reset values within
//    same cycle; o_empty=1, o_count=0.
//  2 order: push 0x11,0x22,0x33 then rd x3 -> o_cmd 0x11,0x22,0x33 in order, o_empty=1 after.
//  3 full/wrap (DEPTH=4): push 5 -> o_full after 4th, 5th dropped, o_overflow=1; pop 2, push 2
//    -> pointers wrap, pop order intact, o_count=4.
//  4 simultaneous: count=2, push+rd for 10 cycles -> o_count stays 2, output sequence correct;
//    full + push + rd -> push dropped, o_overflow=1, count=3.
//  5 flush/underflow: rd on empty -> o_underflow=1; 3 entries + i_flush with push -> count=0,
//    flags=0, pushed cmd discarded.
//  6 bypass: empty, push 0xAB with rd same cycle -> with CMDQ_BYPASS_EN o_cmd=0xAB, count stays 0,
//    no underflow; without it o_underflow=1, count=1 next cycle.

Source files
------------

// File: rtl/cmd_queue_fifo.sv
// cmd_queue_fifo: show-ahead command FIFO with fill level and sticky overflow/underflow status.
// Define CMDQ_BYPASS_EN to let a push into an empty queue reach o_cmd in the same cycle.
module cmd_queue_fifo #(
  parameter int CMD_W        = 64,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [CMD_W-1:0]         i_push_cmd,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic [CMD_W-1:0]         o_cmd,
  output logic                     o_empty,
  input  logic                     i_rd,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_THRESH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty_q;
  logic             w_full;
  logic [AW:0]      w_count;
  logic             w_bypass;
  logic             w_bypass_take;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic             w_overflow_ev;
  logic             w_underflow_ev;

  // Extra wrap bit on each pointer tells full apart from empty when the addresses match.
  assign w_empty_q = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_count   = r_wr_ptr - r_rd_ptr;

`ifdef CMDQ_BYPASS_EN
  assign w_bypass = w_empty_q && i_push && !i_flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed command that is read in the same cycle never touches storage.
  assign w_bypass_take  = w_bypass && i_rd;
  assign w_push_ok      = i_push && !w_full && !w_bypass_take;
  assign w_pop_ok       = i_rd && !w_empty_q;
  assign w_overflow_ev  = i_push && w_full;
  assign w_underflow_ev = i_rd && w_empty_q && !w_bypass;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok)      r_wr_ptr    <= r_wr_ptr + 1'b1;
      if (w_pop_ok)       r_rd_ptr    <= r_rd_ptr + 1'b1;
      if (w_overflow_ev)  r_overflow  <= 1'b1;
      if (w_underflow_ev) r_underflow <= 1'b1;
    end
  end

  // Storage is not reset; o_cmd masking keeps stale words from ever being visible.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_cmd;
  end

  always_comb begin
    o_cmd = '0;
    if (w_bypass)        o_cmd = i_push_cmd;
    else if (!w_empty_q) o_cmd = r_mem[r_rd_ptr[AW-1:0]];
  end

  assign o_empty       = w_empty_q && !w_bypass;
  assign o_full        = w_full;
  assign o_count       = w_count;
  assign o_almost_full = (w_count >= AFULL_LVL);
  assign o_overflow    = r_overflow;
  assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_cmd_queue_fifo.sv
// Self-checking bench for cmd_queue_fifo (DEPTH=4) against a queue-based reference model.
module tb_cmd_queue_fifo;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int AF = 3;
`ifdef CMDQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush, push, rd;
  logic [W-1:0] push_cmd;
  logic         full, afull, empty, ovf, unf;
  logic [W-1:0] cmd;
  logic [2:0]   count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m_q[$];
  bit           m_ovf, m_unf;

  cmd_queue_fifo #(.CMD_W(W), .DEPTH(D), .AFULL_THRESH(AF)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_flush(flush), .i_push(push), .i_push_cmd(push_cmd),
    .o_full(full), .o_almost_full(afull), .o_cmd(cmd), .o_empty(empty), .i_rd(rd),
    .o_count(count), .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: one clock edge worth of the queue's rules.
  task automatic model_step(input bit p, input logic [W-1:0] c, input bit r, input bit f);
    bit byp, was_empty, was_full;
    if (f) begin
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
      return;
    end
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == D);
    byp       = BYP && was_empty && p;
    if (p && was_full) m_ovf = 1;
    if (r && was_empty && !byp) m_unf = 1;
    if (byp && r) return;
    if (r && !was_empty) void'(m_q.pop_front());
    if (p && !was_full) m_q.push_back(c);
  endtask

  // Called at a falling edge; returns at the next falling edge with inputs idle.
  task automatic drive(input bit p, input logic [W-1:0] c, input bit r, input bit f);
    push = p; push_cmd = c; rd = r; flush = f;
    @(posedge clk);
    model_step(p, c, r, f);
    #1;
    push = 0; rd = 0; flush = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 0; push = 0; rd = 0; flush = 0; push_cmd = '0;
    m_q.delete(); m_ovf = 0; m_unf = 0;
    repeat (2) @(negedge clk);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (cmd !== '0) begin n_fail++; $display("FAIL reset_cmd: got %h want 0", cmd); end
    rstn = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) drive(1, 32'h100 + i, 0, 0);
    drive(0, '0, 1, 0);
    drive(1, 32'h200, 0, 0);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL reset_pre_ovf: got %b want 1", ovf); end
    // Assert reset away from any edge and look immediately.
    #2 rstn = 0;
    #1;
    m_q.delete(); m_ovf = 0; m_unf = 0;
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_mid_empty: got %b want 1", empty); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_mid_count: got %0d want 0", count); end
    n_tests++; if (full !== 1'b0 || afull !== 1'b0) begin n_fail++; $display("FAIL reset_mid_full: got full=%b afull=%b want 0 0", full, afull); end
    n_tests++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_fail++; $display("FAIL reset_mid_flags: got ovf=%b unf=%b want 0 0", ovf, unf); end
    n_tests++; if (cmd !== '0) begin n_fail++; $display("FAIL reset_mid_cmd: got %h want 0", cmd); end
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_order();
    logic [W-1:0] exp_v [3];
    exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33;
    for (int i = 0; i < 3; i++) drive(1, exp_v[i], 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (cmd !== exp_v[i]) begin n_fail++; $display("FAIL order_cmd%0d: got %h want %h", i, cmd, exp_v[i]); end
      drive(0, '0, 1, 0);
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL order_empty: got %b want 1", empty); end
    n_tests++; if (cmd !== '0) begin n_fail++; $display("FAIL order_masked: got %h want 0", cmd); end
  endtask

  task automatic test_full_wrap();
    logic [W-1:0] exp_v [4];
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'hA0 + i, 0, 0);
      if (i == 3) begin
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL wrap_full4: got %b want 1", full); end
      end
    end
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL wrap_count5: got %0d want 4", count); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf: got %b want 1", ovf); end
    for (int i = 0; i < 2; i++) begin
      n_tests++; if (cmd !== 32'hA0 + i) begin n_fail++; $display("FAIL wrap_pop%0d: got %h want %h", i, cmd, 32'hA0 + i); end
      drive(0, '0, 1, 0);
    end
    drive(1, 32'hB0, 0, 0);
    drive(1, 32'hB1, 0, 0);
    n_tests++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL wrap_refill: got count=%0d full=%b want 4 1", count, full); end
    exp_v[0] = 32'hA2; exp_v[1] = 32'hA3; exp_v[2] = 32'hB0; exp_v[3] = 32'hB1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (cmd !== exp_v[i]) begin n_fail++; $display("FAIL wrap_order%0d: got %h want %h", i, cmd, exp_v[i]); end
      drive(0, '0, 1, 0);
    end
    drive(0, '0, 0, 1);
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] exp_head;
    drive(1, 32'hC0, 0, 0);
    drive(1, 32'hC1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      exp_head = (i < 2) ? 32'hC0 + i : 32'hD0 + (i - 2);
      n_tests++; if (cmd !== exp_head) begin n_fail++; $display("FAIL simul_head%0d: got %h want %h", i, cmd, exp_head); end
      drive(1, 32'hD0 + i, 1, 0);
      n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_count%0d: got %0d want 2", i, count); end
    end
    drive(1, 32'hE0, 0, 0);
    drive(1, 32'hE1, 0, 0);
    n_tests++; if (full !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL simul_full: got full=%b ovf=%b want 1 0", full, ovf); end
    drive(1, 32'hFF, 1, 0);
    n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL simul_fullpr_count: got %0d want 3", count); end
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL simul_fullpr_ovf: got %b want 1", ovf); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (cmd !== m_q[0]) begin n_fail++; $display("FAIL simul_drain%0d: got %h want %h", i, cmd, m_q[0]); end
      n_tests++; if (cmd === 32'hFF) begin n_fail++; $display("FAIL simul_dropped%0d: got %h want not ff", i, cmd); end
      drive(0, '0, 1, 0);
    end
    drive(0, '0, 0, 1);
  endtask

  task automatic test_flush_underflow();
    drive(0, '0, 1, 0);
    n_tests++; if (unf !== 1'b1) begin n_fail++; $display("FAIL flush_unf: got %b want 1", unf); end
    for (int i = 0; i < 3; i++) drive(1, 32'h300 + i, 0, 0);
    drive(1, 32'h3FF, 0, 1);
    n_tests++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_count: got count=%0d empty=%b want 0 1", count, empty); end
    n_tests++; if (unf !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL flush_flags: got ovf=%b unf=%b want 0 0", ovf, unf); end
    n_tests++; if (cmd !== '0) begin n_fail++; $display("FAIL flush_cmd: got %h want 0", cmd); end
    drive(1, 32'h310, 0, 0);
    n_tests++; if (cmd !== 32'h310 || count !== 3'd1) begin n_fail++; $display("FAIL flush_after: got cmd=%h count=%0d want 310 1", cmd, count); end
    drive(0, '0, 0, 1);
  endtask

  task automatic test_bypass();
    push = 1; push_cmd = 32'hAB; rd = 1; flush = 0;
    #1;
    n_tests++; if (cmd !== (BYP ? 32'hAB : 32'h0)) begin n_fail++; $display("FAIL byp_cmd: got %h want %h", cmd, BYP ? 32'hAB : 32'h0); end
    n_tests++; if (empty !== !BYP) begin n_fail++; $display("FAIL byp_empty: got %b want %b", empty, !BYP); end
    @(posedge clk);
    model_step(1, 32'hAB, 1, 0);
    #1; push = 0; rd = 0;
    @(negedge clk);
    n_tests++; if (count !== (BYP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL byp_count: got %0d want %0d", count, BYP ? 0 : 1); end
    n_tests++; if (unf !== !BYP) begin n_fail++; $display("FAIL byp_unf: got %b want %b", unf, !BYP); end
    drive(0, '0, 0, 1);
    // Flush suppresses the bypass path.
    push = 1; push_cmd = 32'hCD; flush = 1;
    #1;
    n_tests++; if (empty !== 1'b1 || cmd !== '0) begin n_fail++; $display("FAIL byp_flush: got empty=%b cmd=%h want 1 0", empty, cmd); end
    @(posedge clk);
    model_step(1, 32'hCD, 0, 1);
    #1; push = 0; flush = 0;
    @(negedge clk);
    drive(1, 32'hCE, 0, 0);
    n_tests++; if (count !== 3'd1 || cmd !== 32'hCE) begin n_fail++; $display("FAIL byp_store: got count=%0d cmd=%h want 1 ce", count, cmd); end
    drive(0, '0, 0, 1);
  endtask

  task automatic test_random();
    bit p, r, f;
    logic [W-1:0] c, exp_cmd;
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 3);
      c = $urandom;
      drive(p, c, r, f);
      exp_cmd = (m_q.size() != 0) ? m_q[0] : '0;
      n_tests++; if (count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rand_count@%0d: got %0d want %0d", i, count, m_q.size()); end
      n_tests++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL rand_cmd@%0d: got %h want %h", i, cmd, exp_cmd); end
      n_tests++; if (empty !== (m_q.size() == 0) || full !== (m_q.size() == D)) begin n_fail++; $display("FAIL rand_empty_full@%0d: got %b%b want %b%b", i, empty, full, m_q.size() == 0, m_q.size() == D); end
      n_tests++; if (afull !== (m_q.size() >= AF)) begin n_fail++; $display("FAIL rand_afull@%0d: got %b want %b", i, afull, m_q.size() >= AF); end
      n_tests++; if (ovf !== m_ovf || unf !== m_unf) begin n_fail++; $display("FAIL rand_flags@%0d: got ovf=%b unf=%b want %b %b", i, ovf, unf, m_ovf, m_unf); end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_wrap();
    test_simultaneous();
    test_flush_underflow();
    test_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
